// File: rtl/pkg_asteroide.sv
// Shared definitions for the asteroid spawn scheduler: state codes and the
// LFSR polynomial/seed used to randomise spawn position and heading.
package pkg_asteroide;

   typedef enum logic [3:0] {
      ST_INICIAL         = 4'h0,
      ST_OCIOSO          = 4'h1,
      ST_CARREGA_PERIODO = 4'h2,
      ST_CONTA           = 4'h3,
      ST_SORTEIA         = 4'h4,
      ST_SOLICITA        = 4'h5,
      ST_AGUARDA_FIM     = 4'h6,
      ST_ATUALIZA_NIVEL  = 4'h7,
      ST_PAUSADO         = 4'h8,
      ST_ERRO            = 4'hF
   } estado_t;

   localparam logic [15:0] LFSR_MASCARA   = 16'hB400;
   localparam logic [15:0] SEMENTE_PADRAO = 16'hACE1;

   // One Galois step: shift right and fold the polynomial in when bit 0 leaves
   function automatic logic [15:0] proximoLfsr(input logic [15:0] valorAtual);
      return {1'b0, valorAtual[15:1]} ^ (valorAtual[0] ? LFSR_MASCARA : 16'h0000);
   endfunction

endpackage

// File: rtl/lfsr_asteroide.sv
// Free-running 16-bit Galois LFSR; advances every clock and restarts from the
// seed on reset. The seed must never be zero or the sequence locks up.
module lfsr_asteroide
   import pkg_asteroide::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] semente,
   output logic [15:0] valor
);

   logic [15:0] valor_q;
   logic [15:0] valor_d;

   assign valor_d = proximoLfsr(valor_q);
   assign valor   = valor_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valor_q <= semente;
      end else begin
         valor_q <= valor_d;
      end
   end

endmodule

// File: rtl/agendador_asteroide.sv
// Asteroid spawn scheduler: counts time-base ticks, requests a spawn at a
// random border position, waits for the generator and ramps difficulty.
module agendador_asteroide
   import pkg_asteroide::*;
#(
   parameter int          PERIODO_INICIAL = 50,
   parameter int          PERIODO_MINIMO  = 10,
   parameter int          DECREMENTO      = 5,
   parameter int          N_ONDA          = 8,
   parameter int          TIMEOUT         = 64,
   parameter logic [15:0] SEMENTE         = SEMENTE_PADRAO
)(
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       game_over,
   input  logic       pausa,
   input  logic       tick,
   input  logic       fim_gera_asteroide,
   output logic       gera_asteroide,
   output logic [3:0] pos_x,
   output logic [3:0] pos_y,
   output logic [2:0] direcao,
   output logic [3:0] nivel,
   output logic [7:0] periodo_atual,
   output logic       erro_timeout,
   output logic [3:0] db_estado
);

   localparam logic [7:0]  PERIODO_INI   = 8'(PERIODO_INICIAL);
   localparam logic [7:0]  PERIODO_MIN   = 8'(PERIODO_MINIMO);
   localparam logic [7:0]  PASSO         = 8'(DECREMENTO);
   localparam logic [8:0]  LIMIAR_PASSO  = 9'(PERIODO_MINIMO + DECREMENTO);
   localparam logic [7:0]  TAMANHO_ONDA  = 8'(N_ONDA);
   localparam logic [15:0] LIMITE_ESPERA = 16'(TIMEOUT - 1);

   estado_t     estado_q, estado_d;
   logic [7:0]  tickCnt_q, tickCnt_d;
   logic [7:0]  spawnCnt_q, spawnCnt_d;
   logic [15:0] waitCnt_q, waitCnt_d;
   logic [3:0]  nivel_q, nivel_d;
   logic [7:0]  periodo_q, periodo_d;
   logic [3:0]  posX_q, posX_d;
   logic [3:0]  posY_q, posY_d;
   logic [2:0]  direcao_q, direcao_d;

   logic [15:0] lfsrValor;
   logic [7:0]  spawnNovo;
   logic        unusedLfsrBits;

   lfsr_asteroide uLfsr (
      .clock   (clock),
      .reset   (reset),
      .semente (SEMENTE),
      .valor   (lfsrValor)
   );

   assign spawnNovo      = spawnCnt_q + 8'd1;
   assign unusedLfsrBits = ^{lfsrValor[15:13], lfsrValor[7:4]};

   // Outputs decoded from the state so a reset drops the request immediately
   assign gera_asteroide = (estado_q == ST_SOLICITA);
   assign erro_timeout   = (estado_q == ST_ERRO);
   assign db_estado      = estado_q;
   assign pos_x          = posX_q;
   assign pos_y          = posY_q;
   assign direcao        = direcao_q;
   assign nivel          = nivel_q;
   assign periodo_atual  = periodo_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q   <= ST_INICIAL;
         tickCnt_q  <= '0;
         spawnCnt_q <= '0;
         waitCnt_q  <= '0;
         nivel_q    <= '0;
         periodo_q  <= PERIODO_INI;
         posX_q     <= '0;
         posY_q     <= '0;
         direcao_q  <= '0;
      end else begin
         estado_q   <= estado_d;
         tickCnt_q  <= tickCnt_d;
         spawnCnt_q <= spawnCnt_d;
         waitCnt_q  <= waitCnt_d;
         nivel_q    <= nivel_d;
         periodo_q  <= periodo_d;
         posX_q     <= posX_d;
         posY_q     <= posY_d;
         direcao_q  <= direcao_d;
      end
   end

   always_comb begin
      estado_d   = estado_q;
      tickCnt_d  = tickCnt_q;
      spawnCnt_d = spawnCnt_q;
      waitCnt_d  = waitCnt_q;
      nivel_d    = nivel_q;
      periodo_d  = periodo_q;
      posX_d     = posX_q;
      posY_d     = posY_q;
      direcao_d  = direcao_q;

      case (estado_q)
         ST_INICIAL: estado_d = ST_OCIOSO;
         ST_OCIOSO: begin
            if (iniciar) estado_d = ST_CARREGA_PERIODO;
         end
         ST_CARREGA_PERIODO: begin
            tickCnt_d = '0;
            estado_d  = ST_CONTA;
         end
         // Pause is checked before tick so a tick arriving with pausa is lost
         ST_CONTA: begin
            if (pausa) begin
               estado_d = ST_PAUSADO;
            end else if (tick) begin
               if (tickCnt_q == periodo_q - 8'd1) estado_d = ST_SORTEIA;
               else tickCnt_d = tickCnt_q + 8'd1;
            end
         end
         ST_PAUSADO: begin
            if (!pausa) estado_d = ST_CONTA;
         end
         // Bit 11 picks a vertical or horizontal border, bit 12 which side
         ST_SORTEIA: begin
            if (!lfsrValor[11]) begin
               posX_d = lfsrValor[12] ? 4'd15 : 4'd0;
               posY_d = lfsrValor[3:0];
            end else begin
               posY_d = lfsrValor[12] ? 4'd15 : 4'd0;
               posX_d = lfsrValor[3:0];
            end
            direcao_d = lfsrValor[10:8];
            estado_d  = ST_SOLICITA;
         end
         ST_SOLICITA: begin
            waitCnt_d = '0;
            estado_d  = ST_AGUARDA_FIM;
         end
         ST_AGUARDA_FIM: begin
            if (fim_gera_asteroide) begin
               spawnCnt_d = spawnNovo;
               estado_d   = (spawnNovo == TAMANHO_ONDA) ? ST_ATUALIZA_NIVEL : ST_CARREGA_PERIODO;
            end else if (waitCnt_q == LIMITE_ESPERA) begin
               estado_d = ST_ERRO;
            end else begin
               waitCnt_d = waitCnt_q + 16'd1;
            end
         end
         // Compare before subtracting so a small period can never wrap
         ST_ATUALIZA_NIVEL: begin
            spawnCnt_d = '0;
            if ({1'b0, periodo_q} >= LIMIAR_PASSO) periodo_d = periodo_q - PASSO;
            else periodo_d = PERIODO_MIN;
            if (nivel_q != 4'd15) nivel_d = nivel_q + 4'd1;
            estado_d = ST_CARREGA_PERIODO;
         end
         ST_ERRO: estado_d = ST_ERRO;
         default: estado_d = ST_ERRO;
      endcase

      if (game_over && (estado_q != ST_INICIAL) && (estado_q != ST_ERRO)) begin
         estado_d   = ST_OCIOSO;
         tickCnt_d  = '0;
         spawnCnt_d = '0;
         nivel_d    = '0;
         periodo_d  = PERIODO_INI;
      end
   end

endmodule

// File: tb/tb_agendador_asteroide.sv
// Directed self-checking bench for agendador_asteroide with a short period,
// two-spawn waves and an 8-cycle acknowledgement window.
module tb_agendador_asteroide;

   logic       clock;
   logic       reset;
   logic       iniciar;
   logic       game_over;
   logic       pausa;
   logic       tick;
   logic       fim_gera_asteroide;
   logic       gera_asteroide;
   logic [3:0] pos_x;
   logic [3:0] pos_y;
   logic [2:0] direcao;
   logic [3:0] nivel;
   logic [7:0] periodo_atual;
   logic       erro_timeout;
   logic [3:0] db_estado;

   int assertCount = 0;
   int failCount   = 0;

   agendador_asteroide #(
      .PERIODO_INICIAL (4),
      .PERIODO_MINIMO  (2),
      .DECREMENTO      (1),
      .N_ONDA          (2),
      .TIMEOUT         (8)
   ) dut (
      .clock              (clock),
      .reset              (reset),
      .iniciar            (iniciar),
      .game_over          (game_over),
      .pausa              (pausa),
      .tick               (tick),
      .fim_gera_asteroide (fim_gera_asteroide),
      .gera_asteroide     (gera_asteroide),
      .pos_x              (pos_x),
      .pos_y              (pos_y),
      .direcao            (direcao),
      .nivel              (nivel),
      .periodo_atual      (periodo_atual),
      .erro_timeout       (erro_timeout),
      .db_estado          (db_estado)
   );

   // Free-running clock, period 10
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Last-resort guard so a stuck run still ends
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [15:0] galoisModel(input logic [15:0] v);
      galoisModel = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic applyReset();
      iniciar = 0; game_over = 0; pausa = 0; tick = 0; fim_gera_asteroide = 0;
      reset = 1;
      step();
      step();
      reset = 0;
   endtask

   // Leaves the DUT in conta with the tick counter cleared, 3 edges after reset
   task automatic startGame();
      applyReset();
      step();
      iniciar = 1;
      step();
      iniciar = 0;
      step();
   endtask

   task automatic waitGera(input int limite, output bit found);
      found = 0;
      for (int i = 0; i < limite && !found; i++) begin
         step();
         if (gera_asteroide === 1'b1) found = 1;
      end
   endtask

   task automatic test_reset();
      iniciar = 0; game_over = 0; pausa = 0; tick = 0; fim_gera_asteroide = 0;
      reset = 1;
      step();
      assertCount++; if (db_estado !== 4'h0) begin failCount++; $display("[TB] FAIL reset_db_estado: got %0h expected 0", db_estado); end
      assertCount++; if (gera_asteroide !== 1'b0) begin failCount++; $display("[TB] FAIL reset_gera: got %0b expected 0", gera_asteroide); end
      assertCount++; if (erro_timeout !== 1'b0) begin failCount++; $display("[TB] FAIL reset_erro: got %0b expected 0", erro_timeout); end
      assertCount++; if (nivel !== 4'd0) begin failCount++; $display("[TB] FAIL reset_nivel: got %0d expected 0", nivel); end
      assertCount++; if (periodo_atual !== 8'd4) begin failCount++; $display("[TB] FAIL reset_periodo: got %0d expected 4", periodo_atual); end
      assertCount++; if ({pos_x, pos_y, direcao} !== 11'd0) begin failCount++; $display("[TB] FAIL reset_spawn_outputs: got x=%0d y=%0d dir=%0d expected all 0", pos_x, pos_y, direcao); end
      reset = 0;
      step();
      assertCount++; if (db_estado !== 4'h1) begin failCount++; $display("[TB] FAIL reset_to_ocioso: got %0h expected 1", db_estado); end
      step();
      assertCount++; if (db_estado !== 4'h1) begin failCount++; $display("[TB] FAIL ocioso_holds: got %0h expected 1", db_estado); end
   endtask

   task automatic test_spawn_latency();
      startGame();
      assertCount++; if (db_estado !== 4'h3) begin failCount++; $display("[TB] FAIL latency_in_conta: got %0h expected 3", db_estado); end
      tick = 1;
      for (int k = 1; k <= 3; k++) begin
         step();
         assertCount++; if ({gera_asteroide, db_estado} !== 5'h03) begin failCount++; $display("[TB] FAIL latency_tick%0d: got gera=%0b st=%0h expected gera=0 st=3", k, gera_asteroide, db_estado); end
      end
      step();
      assertCount++; if ({gera_asteroide, db_estado} !== 5'h04) begin failCount++; $display("[TB] FAIL latency_sorteia: got gera=%0b st=%0h expected gera=0 st=4", gera_asteroide, db_estado); end
      tick = 0;
      step();
      assertCount++; if ({gera_asteroide, db_estado} !== 5'h15) begin failCount++; $display("[TB] FAIL latency_gera: got gera=%0b st=%0h expected gera=1 st=5", gera_asteroide, db_estado); end
      step();
      assertCount++; if ({gera_asteroide, db_estado} !== 5'h06) begin failCount++; $display("[TB] FAIL latency_aguarda: got gera=%0b st=%0h expected gera=0 st=6", gera_asteroide, db_estado); end
   endtask

   task automatic test_levels();
      logic [7:0] expPer [6];
      logic [3:0] expNiv [6];
      bit found;
      expPer = '{8'd4, 8'd4, 8'd3, 8'd3, 8'd2, 8'd2};
      expNiv = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2};
      startGame();
      tick = 1;
      for (int i = 0; i < 6; i++) begin
         waitGera(40, found);
         assertCount++; if (found !== 1'b1) begin failCount++; $display("[TB] FAIL levels_spawn%0d_seen: got %0b expected 1", i + 1, found); end
         assertCount++; if (periodo_atual !== expPer[i]) begin failCount++; $display("[TB] FAIL levels_periodo%0d: got %0d expected %0d", i + 1, periodo_atual, expPer[i]); end
         assertCount++; if (nivel !== expNiv[i]) begin failCount++; $display("[TB] FAIL levels_nivel%0d: got %0d expected %0d", i + 1, nivel, expNiv[i]); end
         step();
         step();
         fim_gera_asteroide = 1;
         step();
         fim_gera_asteroide = 0;
         assertCount++; if (db_estado !== ((i % 2 == 1) ? 4'h7 : 4'h2)) begin failCount++; $display("[TB] FAIL levels_after_ack%0d: got %0h expected %0h", i + 1, db_estado, (i % 2 == 1) ? 4'h7 : 4'h2); end
      end
      step();
      assertCount++; if ({nivel, periodo_atual} !== {4'd3, 8'd2}) begin failCount++; $display("[TB] FAIL levels_final: got nivel=%0d periodo=%0d expected nivel=3 periodo=2", nivel, periodo_atual); end
      tick = 0;
   endtask

   task automatic test_pause();
      startGame();
      tick = 1;
      step();
      step();
      pausa = 1;
      for (int k = 0; k < 10; k++) begin
         step();
         assertCount++; if ({gera_asteroide, db_estado} !== 5'h08) begin failCount++; $display("[TB] FAIL pause_cycle%0d: got gera=%0b st=%0h expected gera=0 st=8", k, gera_asteroide, db_estado); end
      end
      pausa = 0;
      tick = 0;
      step();
      assertCount++; if (db_estado !== 4'h3) begin failCount++; $display("[TB] FAIL pause_release: got %0h expected 3", db_estado); end
      tick = 1;
      step();
      assertCount++; if (db_estado !== 4'h3) begin failCount++; $display("[TB] FAIL pause_tick3: got %0h expected 3", db_estado); end
      step();
      assertCount++; if (db_estado !== 4'h4) begin failCount++; $display("[TB] FAIL pause_tick4: got %0h expected 4", db_estado); end
      tick = 0;
      step();
      assertCount++; if (gera_asteroide !== 1'b1) begin failCount++; $display("[TB] FAIL pause_spawn: got %0b expected 1", gera_asteroide); end
   endtask

   task automatic test_timeout();
      bit found;
      startGame();
      tick = 1;
      waitGera(20, found);
      assertCount++; if (found !== 1'b1) begin failCount++; $display("[TB] FAIL timeout_spawn_seen: got %0b expected 1", found); end
      tick = 0;
      step();
      assertCount++; if (db_estado !== 4'h6) begin failCount++; $display("[TB] FAIL timeout_enter: got %0h expected 6", db_estado); end
      for (int k = 1; k <= 7; k++) begin
         step();
         assertCount++; if ({erro_timeout, db_estado} !== 5'h06) begin failCount++; $display("[TB] FAIL timeout_wait%0d: got erro=%0b st=%0h expected erro=0 st=6", k, erro_timeout, db_estado); end
      end
      step();
      assertCount++; if ({erro_timeout, db_estado} !== 5'h1F) begin failCount++; $display("[TB] FAIL timeout_erro: got erro=%0b st=%0h expected erro=1 st=F", erro_timeout, db_estado); end
      game_over = 1; iniciar = 1; fim_gera_asteroide = 1;
      for (int k = 0; k < 4; k++) begin
         step();
         assertCount++; if ({erro_timeout, db_estado} !== 5'h1F) begin failCount++; $display("[TB] FAIL timeout_sticky%0d: got erro=%0b st=%0h expected erro=1 st=F", k, erro_timeout, db_estado); end
      end
      game_over = 0; iniciar = 0; fim_gera_asteroide = 0;
      reset = 1;
      #1;
      assertCount++; if ({erro_timeout, db_estado} !== 5'h00) begin failCount++; $display("[TB] FAIL timeout_reset: got erro=%0b st=%0h expected erro=0 st=0", erro_timeout, db_estado); end
      step();
      reset = 0;
   endtask

   task automatic test_game_over_vs_ack();
      bit found;
      startGame();
      tick = 1;
      for (int i = 0; i < 2; i++) begin
         waitGera(20, found);
         assertCount++; if (found !== 1'b1) begin failCount++; $display("[TB] FAIL gover_spawn%0d_seen: got %0b expected 1", i + 1, found); end
         step();
         fim_gera_asteroide = 1;
         step();
         fim_gera_asteroide = 0;
      end
      step();
      assertCount++; if ({nivel, periodo_atual} !== {4'd1, 8'd3}) begin failCount++; $display("[TB] FAIL gover_level_up: got nivel=%0d periodo=%0d expected nivel=1 periodo=3", nivel, periodo_atual); end
      waitGera(20, found);
      step();
      fim_gera_asteroide = 1;
      game_over = 1;
      step();
      fim_gera_asteroide = 0;
      game_over = 0;
      assertCount++; if ({db_estado, nivel, periodo_atual} !== {4'h1, 4'd0, 8'd4}) begin failCount++; $display("[TB] FAIL gover_abort: got st=%0h nivel=%0d periodo=%0d expected st=1 nivel=0 periodo=4", db_estado, nivel, periodo_atual); end
      iniciar = 1;
      step();
      iniciar = 0;
      waitGera(20, found);
      assertCount++; if (found !== 1'b1) begin failCount++; $display("[TB] FAIL gover_restart_spawn: got %0b expected 1", found); end
      step();
      fim_gera_asteroide = 1;
      step();
      fim_gera_asteroide = 0;
      assertCount++; if (db_estado !== 4'h2) begin failCount++; $display("[TB] FAIL gover_spawn_count_cleared: got %0h expected 2", db_estado); end
      tick = 0;
   endtask

   task automatic test_lfsr_spawn();
      logic [15:0] v;
      logic [3:0]  expX, expY;
      logic [2:0]  expDir;
      v = 16'hACE1;
      for (int k = 0; k < 7; k++) v = galoisModel(v);
      if (!v[11]) begin
         expX = v[12] ? 4'd15 : 4'd0;
         expY = v[3:0];
      end else begin
         expY = v[12] ? 4'd15 : 4'd0;
         expX = v[3:0];
      end
      expDir = v[10:8];
      startGame();
      tick = 1;
      for (int k = 0; k < 4; k++) step();
      tick = 0;
      step();
      assertCount++; if (gera_asteroide !== 1'b1) begin failCount++; $display("[TB] FAIL lfsr_fixed_cycle_gera: got %0b expected 1", gera_asteroide); end
      assertCount++; if ({pos_x, pos_y, direcao} !== {expX, expY, expDir}) begin failCount++; $display("[TB] FAIL lfsr_spawn_values: got x=%0d y=%0d dir=%0d expected x=%0d y=%0d dir=%0d", pos_x, pos_y, direcao, expX, expY, expDir); end
      assertCount++; if (!(pos_x === 4'd0 || pos_x === 4'd15 || pos_y === 4'd0 || pos_y === 4'd15)) begin failCount++; $display("[TB] FAIL lfsr_on_border: got x=%0d y=%0d expected one coordinate 0 or 15", pos_x, pos_y); end
      reset = 1;
      #1;
      assertCount++; if (gera_asteroide !== 1'b0) begin failCount++; $display("[TB] FAIL reset_mid_handshake: got %0b expected 0", gera_asteroide); end
      fim_gera_asteroide = 1;
      step();
      reset = 0;
      step();
      step();
      fim_gera_asteroide = 0;
      assertCount++; if ({gera_asteroide, db_estado} !== 5'h01) begin failCount++; $display("[TB] FAIL reset_discards_ack: got gera=%0b st=%0h expected gera=0 st=1", gera_asteroide, db_estado); end
   endtask

   initial begin
      reset = 1;
      iniciar = 0; game_over = 0; pausa = 0; tick = 0; fim_gera_asteroide = 0;
      test_reset();
      test_spawn_latency();
      test_levels();
      test_pause();
      test_timeout();
      test_game_over_vs_ack();
      test_lfsr_spawn();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
